// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one synchronous 8-entry register file between
// two requesters (m0, m1). One op is in flight at a time: writes are posted
// (no response), reads return both addressed values over a valid/ready channel.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req_valid/ready         request handshake (ready is combinational)
//   mX_req_we                  1 = write, 0 = read
//   mX_req_addr_a/addr_b       write addr or read addr A / read addr B
//   mX_req_wdata               write data
//   mX_rsp_valid/ready         read response handshake
//   mX_rsp_data_a/data_b       read data for addr_a / addr_b
//   rf_read_port_1/2           regfile read addresses
//   rf_write_port_1            regfile write address
//   rf_write_data              regfile write data
//   rf_write_enable            regfile write strobe
//   rf_read_data_1/2           registered regfile read data
//   busy                       high whenever an op is in flight
module regfile_access_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr_a,
  input  logic [ADDR_W-1:0] m0_req_addr_b,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DATA_W-1:0] m0_rsp_data_a,
  output logic [DATA_W-1:0] m0_rsp_data_b,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr_a,
  input  logic [ADDR_W-1:0] m1_req_addr_b,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DATA_W-1:0] m1_rsp_data_a,
  output logic [DATA_W-1:0] m1_rsp_data_b,
  output logic [ADDR_W-1:0] rf_read_port_1,
  output logic [ADDR_W-1:0] rf_read_port_2,
  output logic [ADDR_W-1:0] rf_write_port_1,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   rr;        // 0: m0 wins on contention, 1: m1 wins
  logic   owner;     // requester whose op is in flight
  logic   op_write;  // in-flight op is a write

  logic              any_valid;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr_a;
  logic [ADDR_W-1:0] sel_addr_b;
  logic [DATA_W-1:0] sel_wdata;
  logic              owner_rsp_ready;

  // Grant selection: sole requester wins, otherwise the one not served last.
  always_comb begin
    any_valid = m0_req_valid | m1_req_valid;
    grant     = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      grant = rr;
    end else if (m1_req_valid) begin
      grant = 1'b1;
    end
  end

  assign m0_req_ready = (state == IDLE) && any_valid && !grant;
  assign m1_req_ready = (state == IDLE) && any_valid &&  grant;

  // Fields of the granted request.
  always_comb begin
    sel_we     = m0_req_we;
    sel_addr_a = m0_req_addr_a;
    sel_addr_b = m0_req_addr_b;
    sel_wdata  = m0_req_wdata;
    if (grant) begin
      sel_we     = m1_req_we;
      sel_addr_a = m1_req_addr_a;
      sel_addr_b = m1_req_addr_b;
      sel_wdata  = m1_req_wdata;
    end
  end

  assign owner_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;

  // Sequencer: accept, drive the regfile, capture read data, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr              <= 1'b0;
      owner           <= 1'b0;
      op_write        <= 1'b0;
      busy            <= 1'b0;
      rf_read_port_1  <= '0;
      rf_read_port_2  <= '0;
      rf_write_port_1 <= '0;
      rf_write_data   <= '0;
      rf_write_enable <= 1'b0;
      m0_rsp_valid    <= 1'b0;
      m0_rsp_data_a   <= '0;
      m0_rsp_data_b   <= '0;
      m1_rsp_valid    <= 1'b0;
      m1_rsp_data_a   <= '0;
      m1_rsp_data_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= grant;
            op_write <= sel_we;
            rr       <= ~grant;
            busy     <= 1'b1;
            state    <= ISSUE;
            if (sel_we) begin
              rf_write_port_1 <= sel_addr_a;
              rf_write_data   <= sel_wdata;
              rf_write_enable <= 1'b1;
            end else begin
              // Read ports only move on reads; they hold across writes.
              rf_read_port_1  <= sel_addr_a;
              rf_read_port_2  <= sel_addr_b;
              rf_write_enable <= 1'b0;
            end
          end
        end
        ISSUE: begin
          rf_write_enable <= 1'b0;
          if (op_write) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (owner) begin
            m1_rsp_data_a <= rf_read_data_1;
            m1_rsp_data_b <= rf_read_data_2;
            m1_rsp_valid  <= 1'b1;
          end else begin
            m0_rsp_data_a <= rf_read_data_1;
            m0_rsp_data_b <= rf_read_data_2;
            m0_rsp_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed and randomized rounds checked
// against a simple model (register array, last-served requester, expected
// latencies). A behavioural synchronous regfile is attached to the rf_* ports.
module tb_regfile_access_arbiter;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_REG  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_req_valid, m0_req_ready, m0_req_we;
  logic [ADDR_W-1:0] m0_req_addr_a, m0_req_addr_b;
  logic [DATA_W-1:0] m0_req_wdata;
  logic              m0_rsp_valid, m0_rsp_ready;
  logic [DATA_W-1:0] m0_rsp_data_a, m0_rsp_data_b;
  logic              m1_req_valid, m1_req_ready, m1_req_we;
  logic [ADDR_W-1:0] m1_req_addr_a, m1_req_addr_b;
  logic [DATA_W-1:0] m1_req_wdata;
  logic              m1_rsp_valid, m1_rsp_ready;
  logic [DATA_W-1:0] m1_rsp_data_a, m1_rsp_data_b;
  logic [ADDR_W-1:0] rf_read_port_1, rf_read_port_2, rf_write_port_1;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;
  logic [DATA_W-1:0] rf_read_data_1, rf_read_data_2;
  logic              busy;

  always #5 clk = ~clk;

  regfile_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr_a(m0_req_addr_a), .m0_req_addr_b(m0_req_addr_b), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_data_a(m0_rsp_data_a), .m0_rsp_data_b(m0_rsp_data_b),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr_a(m1_req_addr_a), .m1_req_addr_b(m1_req_addr_b), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_data_a(m1_rsp_data_a), .m1_rsp_data_b(m1_rsp_data_b),
    .rf_read_port_1(rf_read_port_1), .rf_read_port_2(rf_read_port_2),
    .rf_write_port_1(rf_write_port_1), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .busy(busy)
  );

  // Synchronous regfile: write when enabled, otherwise register both reads.
  logic [DATA_W-1:0] mem [N_REG];
  always @(posedge clk) begin
    if (rf_write_enable) begin
      mem[rf_write_port_1] <= rf_write_data;
    end else begin
      rf_read_data_1 <= mem[rf_read_port_1];
      rf_read_data_2 <= mem[rf_read_port_2];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] ref_mem [N_REG];
  int                last_served = 1;
  logic [ADDR_W-1:0] last_rp1 = '0;
  logic [ADDR_W-1:0] last_rp2 = '0;
  logic [DATA_W-1:0] last_a [2];
  logic [DATA_W-1:0] last_b [2];
  int                acc_cyc = 0;
  int                prev_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [DATA_W-1:0] d);
    if (r == 0) begin
      m0_req_valid = v; m0_req_we = we; m0_req_addr_a = a; m0_req_addr_b = b; m0_req_wdata = d;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_addr_a = a; m1_req_addr_b = b; m1_req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? m0_req_ready : m1_req_ready;
  endfunction
  function automatic logic rv(input int r);
    return (r == 0) ? m0_rsp_valid : m1_rsp_valid;
  endfunction
  function automatic logic [DATA_W-1:0] rda(input int r);
    return (r == 0) ? m0_rsp_data_a : m1_rsp_data_a;
  endfunction
  function automatic logic [DATA_W-1:0] rdb(input int r);
    return (r == 0) ? m0_rsp_data_b : m1_rsp_data_b;
  endfunction

  task automatic set_rsp_ready(input int r, input logic v);
    if (r == 0) m0_rsp_ready = v; else m1_rsp_ready = v;
  endtask

  // One arbitration round: present requests, expect the model's grant, follow
  // the granted op to completion. The loser's request stays asserted.
  task automatic round(input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] b0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic we1, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] b1, input logic [DATA_W-1:0] d1,
                       input int hold);
    int                g;
    int                o;
    logic              ov;
    logic              we;
    logic [ADDR_W-1:0] a, b;
    logic [DATA_W-1:0] d, ea, eb;
    set_req(0, v0, we0, a0, b0, d0);
    set_req(1, v1, we1, a1, b1, d1);
    if (v0 && v1) g = (last_served == 0) ? 1 : 0;
    else          g = v1 ? 1 : 0;
    o  = 1 - g;
    ov = (o == 0) ? v0 : v1;
    we = (g == 0) ? we0 : we1;
    a  = (g == 0) ? a0 : a1;
    b  = (g == 0) ? b0 : b1;
    d  = (g == 0) ? d0 : d1;
    set_rsp_ready(o, 1'($urandom_range(0, 1)));
    #1;
    chk("ready_m0", 32'(m0_req_ready), 32'(g == 0));
    chk("ready_m1", 32'(m1_req_ready), 32'(g == 1));
    chk("busy_idle", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    last_served = g;
    set_req(g, 1'b0, we, a, b, d);
    chk("busy_accept", 32'(busy), 32'(1));
    chk("ready_m0_busy", 32'(m0_req_ready), 32'(0));
    chk("ready_m1_busy", 32'(m1_req_ready), 32'(0));
    chk("we_issue", 32'(rf_write_enable), 32'(we));
    if (we) begin
      chk("wport", 32'(rf_write_port_1), 32'(a));
      chk("wdata", 32'(rf_write_data), 32'(d));
      chk("rport1_hold", 32'(rf_read_port_1), 32'(last_rp1));
      chk("rport2_hold", 32'(rf_read_port_2), 32'(last_rp2));
      ref_mem[a] = d;
      tick();
      chk("we_one_cycle", 32'(rf_write_enable), 32'(0));
      chk("busy_after_write", 32'(busy), 32'(0));
      chk("no_rsp_write", 32'(rv(g)), 32'(0));
    end else begin
      chk("rport1", 32'(rf_read_port_1), 32'(a));
      chk("rport2", 32'(rf_read_port_2), 32'(b));
      last_rp1 = a;
      last_rp2 = b;
      ea = ref_mem[a];
      eb = ref_mem[b];
      tick();
      chk("busy_capture", 32'(busy), 32'(1));
      chk("rsp_early", 32'(rv(g)), 32'(0));
      chk("we_read", 32'(rf_write_enable), 32'(0));
      tick();
      chk("rsp_valid", 32'(rv(g)), 32'(1));
      chk("rsp_other", 32'(rv(o)), 32'(0));
      chk("rsp_data_a", 32'(rda(g)), 32'(ea));
      chk("rsp_data_b", 32'(rdb(g)), 32'(eb));
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", 32'(rv(g)), 32'(1));
        chk("hold_data_a", 32'(rda(g)), 32'(ea));
        chk("hold_data_b", 32'(rdb(g)), 32'(eb));
        chk("hold_busy", 32'(busy), 32'(1));
        chk("hold_other_ready", 32'(rdy(o)), 32'(0));
      end
      set_rsp_ready(g, 1'b1);
      tick();
      set_rsp_ready(g, 1'b0);
      chk("rsp_consumed", 32'(rv(g)), 32'(0));
      chk("busy_after_rsp", 32'(busy), 32'(0));
      chk("persist_a", 32'(rda(g)), 32'(ea));
      chk("persist_b", 32'(rdb(g)), 32'(eb));
      last_a[g] = ea;
      last_b[g] = eb;
    end
    chk("other_rsp_data_a", 32'(rda(o)), 32'(last_a[o]));
    if (ov) chk("resume_other_ready", 32'(rdy(o)), 32'(1));
    set_rsp_ready(o, 1'b0);
  endtask

  initial begin
    logic              v0, v1, w0, w1;
    logic [ADDR_W-1:0] x0, y0, x1, y1;
    logic [DATA_W-1:0] z0, z1, prev3;
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b0;
    m1_rsp_ready = 1'b0;
    last_a[0] = '0; last_b[0] = '0; last_a[1] = '0; last_b[1] = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_we", 32'(rf_write_enable), 32'(0));
    chk("rst_rport1", 32'(rf_read_port_1), 32'(0));
    chk("rst_wport", 32'(rf_write_port_1), 32'(0));
    chk("rst_wdata", 32'(rf_write_data), 32'(0));
    chk("rst_rsp_valid0", 32'(m0_rsp_valid), 32'(0));
    chk("rst_rsp_valid1", 32'(m1_rsp_valid), 32'(0));
    chk("rst_rsp_data0", 32'({m0_rsp_data_a, m0_rsp_data_b}), 32'(0));
    chk("rst_rsp_data1", 32'({m1_rsp_data_a, m1_rsp_data_b}), 32'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // Idle: nothing requested, nothing happens.
    for (int i = 0; i < 3; i++) begin
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_we", 32'(rf_write_enable), 32'(0));
      chk("idle_ready", 32'({m0_req_ready, m1_req_ready}), 32'(0));
      tick();
    end

    // Known contents for every register (reg 0 = 0).
    for (int i = 0; i < int'(N_REG); i++) begin
      round(1'b1, 1'b1, ADDR_W'(i), '0, (i == 0) ? 8'h00 : DATA_W'($urandom),
            1'b0, 1'b0, '0, '0, '0, 0);
    end

    // Write then read-after-write on m0.
    round(1'b1, 1'b1, 3'd2, 3'd0, 8'hCC, 1'b0, 1'b0, '0, '0, '0, 0);
    round(1'b1, 1'b0, 3'd2, 3'd0, 8'h00, 1'b0, 1'b0, '0, '0, '0, 0);
    chk("t1_data_a", 32'(m0_rsp_data_a), 32'(8'hCC));
    chk("t1_data_b", 32'(m0_rsp_data_b), 32'(8'h00));

    // Contention after m0 was served: m1 write first, then m0 sees it.
    round(1'b1, 1'b0, 3'd7, 3'd7, 8'h00, 1'b1, 1'b1, 3'd7, 3'd0, 8'hAA, 0);
    round(1'b1, 1'b0, 3'd7, 3'd7, 8'h00, 1'b0, 1'b0, '0, '0, '0, 0);
    chk("t3_data_a", 32'(m0_rsp_data_a), 32'(8'hAA));
    chk("t3_data_b", 32'(m0_rsp_data_b), 32'(8'hAA));

    // Continuous contending reads alternate at one accept per 4 cycles.
    for (int i = 0; i < 6; i++) begin
      round(1'b1, 1'b0, ADDR_W'($urandom), ADDR_W'($urandom), '0,
            1'b1, 1'b0, ADDR_W'($urandom), ADDR_W'($urandom), '0, 0);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(4));
      prev_acc = acc_cyc;
    end

    // Response back-pressure for 5 cycles while the other requester waits.
    round(1'b1, 1'b1, 3'd4, 3'd0, 8'h3C, 1'b1, 1'b0, 3'd4, 3'd1, '0, 5);
    round(1'b1, 1'b1, 3'd4, 3'd0, 8'h3C, 1'b1, 1'b0, 3'd4, 3'd1, '0, 5);

    // Reset during the write issue cycle: the write must not land.
    prev3 = ref_mem[3];
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 1'b1, 3'd3, 3'd0, 8'h55);
    #1;
    chk("rstw_ready", 32'(m0_req_ready), 32'(1));
    tick();
    chk("rstw_we_issue", 32'(rf_write_enable), 32'(1));
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", 32'(rf_write_enable), 32'(0));
    chk("rstw_busy", 32'(busy), 32'(0));
    chk("rstw_rsp_data", 32'({m0_rsp_data_a, m1_rsp_data_a}), 32'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    last_served = 1;
    last_rp1 = '0; last_rp2 = '0;
    last_a[0] = '0; last_b[0] = '0; last_a[1] = '0; last_b[1] = '0;
    tick();
    round(1'b1, 1'b0, 3'd3, 3'd3, '0, 1'b1, 1'b0, 3'd3, 3'd0, '0, 0);
    chk("rstw_old_value", 32'(m0_rsp_data_a), 32'(prev3));

    // Randomized mix of reads, writes, contention and back-pressure.
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      x0 = ADDR_W'($urandom); y0 = ADDR_W'($urandom); z0 = DATA_W'($urandom);
      x1 = ADDR_W'($urandom); y1 = ADDR_W'($urandom); z1 = DATA_W'($urandom);
      round(v0, w0, x0, y0, z0, v1, w1, x1, y1, z1, $urandom_range(0, 3));
    end

    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("end_idle_busy", 32'(busy), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares one 8-entry register file between two requesters, m0 and m1.
- Each requester issues read or write ops over a valid/ready handshake.
- Arbitrates round-robin, sequences each op onto the register file's address/data/write-enable ports, and returns read data over a valid/ready response channel.
- Sits between the requesters and the synchronous regfile: write on posedge when write_enable=1; otherwise both read ports registered on posedge.

Parameters:
- ADDR_W, 3, register address width (2**ADDR_W entries).
- DATA_W, 8, register data width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- mX_req_valid  in  1  request valid (X=0,1; same set per requester).
- mX_req_ready  out  1  request accepted this edge when valid&&ready.
- mX_req_we  in  1  1=write, 0=read.
- mX_req_addr_a  in  ADDR_W  write address (write) / read address A (read).
- mX_req_addr_b  in  ADDR_W  read address B (ignored for writes).
- mX_req_wdata  in  DATA_W  write data.
- mX_rsp_valid  out  1  read response valid.
- mX_rsp_ready  in  1  response consumed when valid&&ready.
- mX_rsp_data_a  out  DATA_W  data at addr_a.
- mX_rsp_data_b  out  DATA_W  data at addr_b.
- rf_read_port_1  out  ADDR_W  to regfile.
- rf_read_port_2  out  ADDR_W  to regfile.
- rf_write_port_1  out  ADDR_W  to regfile.
- rf_write_data  out  DATA_W  to regfile.
- rf_write_enable  out  1  to regfile.
- rf_read_data_1  in  DATA_W  from regfile (registered).
- rf_read_data_2  in  DATA_W  from regfile (registered).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP. One op outstanding globally; no pipelining.
- Reset (async, immediate):
  - state=IDLE, rr pointer favours m0.
  - All rf_* outputs, rsp_valid, rsp_data and busy = 0.
  - Any in-flight op is dropped; no partial write may occur.
- IDLE:
  - grant = m0 if only m0 valid, m1 if only m1 valid.
  - If both valid: the requester not served last wins (m0 after reset).
  - mX_req_ready = (state==IDLE) && grant==X, combinational from valid and rr. At most one ready high; ready never high outside IDLE.
- Acceptance edge E:
  - Register op fields into rf_* outputs; update rr to favour the other requester; go ISSUE.
  - Write: rf_write_port_1=addr_a, rf_write_data=wdata, rf_write_enable=1.
  - Read: rf_read_port_1=addr_a, rf_read_port_2=addr_b, rf_write_enable=0.
- ISSUE (cycle E..E+1), regfile samples at E+1:
  - Write: rf_write_enable deasserts at E+1; go IDLE. Writes are posted, with no response. The next request can be accepted at E+2.
  - Read: go CAPTURE.
- CAPTURE (E+1..E+2):
  - rf_read_data_1/2 now hold the addressed values; rf_write_enable stays 0.
  - At E+2, capture into the granted requester's rsp_data_a/b, set its rsp_valid; go RESP.
- RESP:
  - rsp_valid and rsp_data held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0; go IDLE.
  - rsp_ready high while rsp_valid low is ignored. The other requester waits.
- Minimum read latency: rsp_valid visible after E+2, i.e. 2 cycles from acceptance. Back-to-back reads with rsp_ready tied high: one accept per 4 cycles.
- rf read port addresses hold their last read values during writes and idle; only rf_write_enable gates writes.
- Hazards: ops are strictly serialized, so a read accepted after a write to the same address returns the new data.
- Requester fields may change while ready=0; only values at the acceptance edge matter.
- Response data registers persist after consumption until overwritten.

Test Plan:
- Reset then m0 write addr 2 = 0xCC, m0 read a=2,b=0 -> rf_write_enable high exactly one cycle; m0_rsp_valid 2 cycles after read accept with data_a=0xCC, data_b=0x00 (after prior write 0 to reg 0).
- m0 and m1 both valid continuously with reads -> grants alternate m0,m1,m0,m1; never both ready; each rsp to the correct requester.
- m1 write 0xAA to reg 7 then m0 read a=7,b=7 in the same idle edge as competing requests -> m1 granted first (m0 served last), m0 reads 0xAA on both outputs.
- Read with rsp_ready held low 5 cycles -> rsp_valid and data stable 5 cycles, busy=1, other requester's ready stays 0; accept resumes the cycle after consumption.
- Assert rst_n low during ISSUE of write 0x55 to reg 3 -> rf_write_enable drops immediately; after reset, read reg 3 returns the previous value, not 0x55.
- Idle with no valids -> busy=0, rf_write_enable=0, no ready asserted.
